// File: rtl/control_unit_if.sv
// Control unit <-> datapath/host signal bundle.
// The master modport is the control unit. The slave modport is the host and datapath side.
interface control_unit_if;
  logic       start;
  logic       mode;
  logic       b;
  logic       sIs6;
  logic [1:0] y_select_next;
  logic [1:0] s_step;
  logic       y_en;
  logic       s_en;
  logic       y_store_x;
  logic       s_add;
  logic       s_zero;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] iter;

  modport master (
    input  start, mode, b, sIs6,
    output y_select_next, s_step, y_en, s_en, y_store_x, s_add, s_zero,
           busy, done, err, iter
  );

  modport slave (
    output start, mode, b, sIs6,
    input  y_select_next, s_step, y_en, s_en, y_store_x, s_add, s_zero,
           busy, done, err, iter
  );
endinterface

// File: rtl/control_unit.sv
// Sequencer for the y/s scan datapath.
// The unit loads x into y, then walks s over 0..6 (every step, or even steps only).
// At each step it adds s to y or subtracts s from y, depending on bit y[s].
// A watchdog stops the scan if s never reaches 6 within 8 update cycles.
module control_unit (
  input  logic                  clk,
  input  logic                  rst,
  control_unit_if.master        cu
);

  typedef enum logic [2:0] {IDLE, LOAD, UPDATE, DONE, ERR} state_t;

  localparam logic [1:0] SEL_HOLD = 2'd0;
  localparam logic [1:0] SEL_ADD  = 2'd2;
  localparam logic [1:0] SEL_SUB  = 2'd3;

  state_t     state_q, state_d;
  logic       mode_q, mode_d;
  logic [2:0] iter_q, iter_d;
  logic       err_q, err_d;
  // In ERR, arm_q records that start has been seen low, so that a later high restarts.
  logic       arm_q, arm_d;

  // State and status registers; reset forces IDLE at once, even mid-operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      iter_q  <= 3'd0;
      err_q   <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
      arm_q   <= arm_d;
    end
  end

  // Next-state logic and datapath control decode.
  always_comb begin
    state_d          = state_q;
    mode_d           = mode_q;
    iter_d           = iter_q;
    err_d            = err_q;
    arm_d            = arm_q;
    cu.y_en          = 1'b0;
    cu.s_en          = 1'b0;
    cu.y_store_x     = 1'b0;
    cu.s_zero        = 1'b0;
    cu.s_add         = 1'b1;
    cu.s_step        = 2'd0;
    cu.y_select_next = SEL_HOLD;
    cu.busy          = 1'b0;
    cu.done          = 1'b0;

    case (state_q)
      IDLE: begin
        if (cu.start) begin
          mode_d  = cu.mode;
          iter_d  = 3'd0;
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end

      LOAD: begin
        cu.busy      = 1'b1;
        cu.y_en      = 1'b1;
        cu.y_store_x = 1'b1;
        cu.s_en      = 1'b1;
        cu.s_zero    = 1'b1;
        state_d      = UPDATE;
      end

      UPDATE: begin
        cu.busy = 1'b1;
        iter_d  = (iter_q == 3'd7) ? 3'd7 : iter_q + 3'd1;
        // iter_q is already saturated at 7 here only in the 8th consecutive update.
        if (!cu.sIs6 && iter_q == 3'd7) begin
          err_d   = 1'b1;
          arm_d   = 1'b0;
          state_d = ERR;
        end else begin
          cu.y_en          = 1'b1;
          cu.y_select_next = cu.b ? SEL_ADD : SEL_SUB;
          if (cu.sIs6) begin
            state_d = DONE;
          end else begin
            cu.s_en   = 1'b1;
            cu.s_step = mode_q ? 2'd2 : 2'd1;
          end
        end
      end

      DONE: begin
        cu.done = 1'b1;
        if (!cu.start) state_d = IDLE;
      end

      ERR: begin
        if (!cu.start) begin
          arm_d = 1'b1;
        end else if (arm_q) begin
          mode_d  = cu.mode;
          iter_d  = 3'd0;
          err_d   = 1'b0;
          arm_d   = 1'b0;
          state_d = LOAD;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign cu.err  = err_q;
  assign cu.iter = iter_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit, driving a behavioural y/s datapath.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_unit_if cu_if ();

  control_unit u_dut (
    .clk (clk),
    .rst (rst),
    .cu  (cu_if)
  );

  // Behavioural datapath with an active-high asynchronous reset.
  logic [7:0] x;
  logic [7:0] y_q;
  logic [2:0] s_q;
  logic       force_no6;
  logic       dp_rst;
  assign dp_rst = ~rst;

  always @(posedge clk or posedge dp_rst) begin
    if (dp_rst) begin
      y_q <= 8'h00;
      s_q <= 3'd0;
    end else begin
      if (cu_if.y_en) begin
        if (cu_if.y_store_x) y_q <= x;
        else case (cu_if.y_select_next)
          2'd1:    y_q <= y_q + 8'd1;
          2'd2:    y_q <= y_q + {5'd0, s_q};
          2'd3:    y_q <= y_q - {5'd0, s_q};
          default: y_q <= y_q;
        endcase
      end
      if (cu_if.s_en) begin
        if (cu_if.s_zero)     s_q <= 3'd0;
        else if (cu_if.s_add) s_q <= s_q + {1'b0, cu_if.s_step};
        else                  s_q <= s_q - {1'b0, cu_if.s_step};
      end
    end
  end

  assign cu_if.b    = y_q[s_q];
  assign cu_if.sIs6 = force_no6 ? 1'b0 : (s_q == 3'd6);

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and step into LOAD; start drops afterwards unless hold is set.
  task automatic go(input logic m, input logic [7:0] xv, input bit hold);
    cu_if.mode  = m;
    x           = xv;
    cu_if.start = 1'b1;
    tick();
    if (!hold) cu_if.start = 1'b0;
  endtask

  // Cycle 1 is the LOAD cycle; returns the cycle index at which done is first seen.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!cu_if.done && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  logic [7:0] yseq [7];
  logic [2:0] sseq [4];
  int cyc;

  initial begin
    yseq = '{8'hFF, 8'h00, 8'hFE, 8'h01, 8'hFD, 8'h02, 8'hFC};
    sseq = '{3'd0, 3'd2, 3'd4, 3'd6};
    rst = 1'b0; cu_if.start = 1'b0; cu_if.mode = 1'b0; x = 8'h00; force_no6 = 1'b0;

    // Reset state
    #12;
    chk("rst_busy", int'(cu_if.busy), 0);
    chk("rst_done", int'(cu_if.done), 0);
    chk("rst_err",  int'(cu_if.err), 0);
    chk("rst_iter", int'(cu_if.iter), 0);
    chk("rst_yen",  int'(cu_if.y_en), 0);
    chk("rst_sadd", int'(cu_if.s_add), 1);
    rst = 1'b1;
    tick();
    chk("release_yen", int'(cu_if.y_en), 0);
    chk("release_sen", int'(cu_if.s_en), 0);

    // Mode 0, x=00
    go(1'b0, 8'h00, 1'b0);
    chk("load_busy",   int'(cu_if.busy), 1);
    chk("load_ystore", int'(cu_if.y_store_x), 1);
    chk("load_szero",  int'(cu_if.s_zero), 1);
    wait_done(cyc);
    chk("m0_done_cycle", cyc, 9);
    chk("m0_y",    int'(y_q), 8'h03);
    chk("m0_iter", int'(cu_if.iter), 7);
    chk("m0_err",  int'(cu_if.err), 0);
    chk("m0_busy", int'(cu_if.busy), 0);
    tick();
    chk("m0_idle_done", int'(cu_if.done), 0);

    // Mode 0, x=FF: y after each update
    go(1'b0, 8'hFF, 1'b0);
    tick();
    chk("ff_ysel", int'(cu_if.y_select_next), 2);
    chk("ff_sen",  int'(cu_if.s_en), 1);
    chk("ff_step", int'(cu_if.s_step), 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("ff_y%0d", i), int'(y_q), int'(yseq[i]));
      if (i == 5) begin
        chk("ff_last_sen", int'(cu_if.s_en), 0);
        chk("ff_last_yen", int'(cu_if.y_en), 1);
      end
    end
    chk("ff_done", int'(cu_if.done), 1);
    tick();

    // Mode 1, x=00; mode flipped and start pulsed mid-operation
    go(1'b1, 8'h00, 1'b0);
    cu_if.mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("m1_s%0d", i), int'(s_q), int'(sseq[i]));
      chk($sformatf("m1_busy%0d", i), int'(cu_if.busy), 1);
      if (i == 0) chk("m1_step", int'(cu_if.s_step), 2);
      if (i == 1) cu_if.start = 1'b1;
      if (i == 2) cu_if.start = 1'b0;
    end
    tick();
    chk("m1_done", int'(cu_if.done), 1);
    chk("m1_y",    int'(y_q), 8'hFC);
    chk("m1_iter", int'(cu_if.iter), 4);
    tick();

    // Asynchronous reset in the 3rd UPDATE cycle
    go(1'b0, 8'h55, 1'b0);
    tick(); tick(); tick();
    chk("pre_rst_busy", int'(cu_if.busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", int'(cu_if.busy), 0);
    chk("arst_yen",  int'(cu_if.y_en), 0);
    chk("arst_sen",  int'(cu_if.s_en), 0);
    chk("arst_iter", int'(cu_if.iter), 0);
    chk("arst_ysel", int'(cu_if.y_select_next), 0);
    #2 rst = 1'b1;
    tick();
    go(1'b0, 8'h00, 1'b0);
    wait_done(cyc);
    chk("post_rst_cycle", cyc, 9);
    chk("post_rst_y", int'(y_q), 8'h03);
    tick();

    // Watchdog: sIs6 never seen
    force_no6 = 1'b1;
    go(1'b0, 8'h00, 1'b0);
    repeat (7) tick();
    chk("wd_upd7_yen", int'(cu_if.y_en), 1);
    tick();
    chk("wd_upd8_yen",  int'(cu_if.y_en), 0);
    chk("wd_upd8_busy", int'(cu_if.busy), 1);
    tick();
    chk("wd_err",  int'(cu_if.err), 1);
    chk("wd_busy", int'(cu_if.busy), 0);
    chk("wd_done", int'(cu_if.done), 0);
    chk("wd_iter", int'(cu_if.iter), 7);
    tick(); tick();
    chk("wd_err_sticky", int'(cu_if.err), 1);
    force_no6 = 1'b0;
    go(1'b0, 8'h00, 1'b0);
    chk("wd_restart_err",  int'(cu_if.err), 0);
    chk("wd_restart_busy", int'(cu_if.busy), 1);
    wait_done(cyc);
    chk("wd_restart_y", int'(y_q), 8'h03);
    tick();

    // start held through DONE
    go(1'b0, 8'h00, 1'b1);
    wait_done(cyc);
    chk("hold_cycle", cyc, 9);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold_done%0d", i), int'(cu_if.done), 1);
      chk($sformatf("hold_yen%0d", i),  int'(cu_if.y_en), 0);
    end
    cu_if.start = 1'b0;
    tick();
    chk("hold_idle_done", int'(cu_if.done), 0);
    tick();
    chk("hold_idle_busy", int'(cu_if.busy), 0);
    chk("hold_idle_yen",  int'(cu_if.y_en), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
